// File: rtl/dmem_access_ctrl.sv
// Memory-stage controller: one load/store per operation, variable-latency
// request/acknowledge data-memory bus, registered result back to write-back,
// pipeline stall for the duration of the access, alignment and timeout errors.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        xfer_byte,
  input  logic [63:0] address,
  input  logic [63:0] write_data,
  output logic        dm_req,
  output logic        dm_we,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_wdata,
  output logic [7:0]  dm_bmask,
  input  logic        dm_ack,
  input  logic [63:0] dm_rdata,
  output logic [63:0] dm_read_data,
  output logic [63:0] dm_address,
  output logic        stall,
  output logic        done,
  output logic        align_err,
  output logic        bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [63:0]      r_addr;
  logic [63:0]      r_wdata;
  logic             r_byte;
  logic             r_we;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_read_data;
  logic [63:0]      r_address;
  logic             r_align_err;
  logic             r_bus_err;

  logic             w_mem_op;
  logic             w_misalign;
  logic             w_cnt_last;
  logic [63:0]      w_lane;
  logic [63:0]      w_byte_rd;

  assign w_mem_op   = op_valid & (mem_read | mem_write);
  assign w_misalign = ~xfer_byte & (address[2:0] != 3'd0);
  assign w_cnt_last = (r_cnt == CNT_LAST);
  // Selected byte lane of the read bus, zero-extended
  assign w_lane     = dm_rdata >> {r_addr[2:0], 3'b000};
  assign w_byte_rd  = {56'd0, w_lane[7:0]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          if (w_mem_op && !w_misalign) w_next = S_REQ;
          else                         w_next = S_DONE;
        end
      end
      S_REQ: begin
        if (dm_ack || w_cnt_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state and latched request; stall also covers the accept cycle
  always_comb begin
    dm_req       = (r_state == S_REQ);
    dm_we        = (r_state == S_REQ) & r_we;
    dm_addr      = r_addr;
    dm_wdata     = r_byte ? {8{r_wdata[7:0]}} : r_wdata;
    dm_bmask     = '0;
    if (r_state == S_REQ) dm_bmask = r_byte ? (8'b1 << r_addr[2:0]) : 8'hFF;
    stall        = ((r_state == S_IDLE) & w_mem_op) | (r_state == S_REQ);
    done         = (r_state == S_DONE);
    dm_read_data = r_read_data;
    dm_address   = r_address;
    align_err    = r_align_err;
    bus_err      = r_bus_err;
  end

  // Request latching, timeout counter, result and error registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_byte      <= 1'b0;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_read_data <= '0;
      r_address   <= '0;
      r_align_err <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_addr      <= address;
            r_wdata     <= write_data;
            r_byte      <= xfer_byte;
            r_we        <= mem_write & ~mem_read;
            r_cnt       <= '0;
            r_align_err <= w_misalign;
            r_bus_err   <= 1'b0;
            if (w_misalign) r_read_data <= '0;
          end else if (op_valid) begin
            r_address <= address;
          end
        end
        S_REQ: begin
          if (dm_ack) begin
            if (!r_we) r_read_data <= r_byte ? w_byte_rd : dm_rdata;
            r_address <= r_addr;
          end else if (w_cnt_last) begin
            r_bus_err   <= 1'b1;
            r_read_data <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed testbench for dmem_access_ctrl with a transaction-level model.
module tb_dmem_access_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, mem_read, mem_write, xfer_byte;
  logic [63:0] address, write_data;
  logic        dm_req, dm_we;
  logic [63:0] dm_addr, dm_wdata;
  logic [7:0]  dm_bmask;
  logic        dm_ack;
  logic [63:0] dm_rdata;
  logic [63:0] dm_read_data, dm_address;
  logic        stall, done, align_err, bus_err;

  dmem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .mem_read(mem_read),
    .mem_write(mem_write), .xfer_byte(xfer_byte), .address(address),
    .write_data(write_data), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_bmask(dm_bmask), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .dm_read_data(dm_read_data), .dm_address(dm_address), .stall(stall),
    .done(done), .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of architecturally visible results
  logic [63:0] m_rd, m_ad;
  logic        m_al, m_be;
  // Expected per-cycle bus/handshake values
  logic        e_stall, e_req, e_done, e_we;
  logic [7:0]  e_bm;
  logic [63:0] e_addr, e_wd;
  logic        chk_en = 1'b0;

  // Per-transaction observations
  int          done_cyc, st_cnt, rq_cnt;
  logic [7:0]  last_bm;
  logic [63:0] last_wd;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", stall, e_stall);
      check("dm_req", dm_req, e_req);
      check("done", done, e_done);
      check("dm_we", dm_we, e_we);
      check("dm_bmask", dm_bmask, e_bm);
      check("align_err", align_err, m_al);
      check("bus_err", bus_err, m_be);
      check("dm_read_data", dm_read_data, m_rd);
      check("dm_address", dm_address, m_ad);
      if (e_req) begin
        check("dm_addr", dm_addr, e_addr);
        check("dm_wdata", dm_wdata, e_wd);
      end
    end
  end

  task automatic set_exp(input logic s, input logic r, input logic d, input logic w,
                         input logic [7:0] bm, input logic [63:0] a, input logic [63:0] wd);
    e_stall = s; e_req = r; e_done = d; e_we = w; e_bm = bm; e_addr = a; e_wd = wd;
  endtask

  task automatic step(input int c);
    @(negedge clk);
    if (stall) st_cnt++;
    if (dm_req) begin rq_cnt++; last_bm = dm_bmask; last_wd = dm_wdata; end
    if (done && done_cyc < 0) done_cyc = c;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    op_valid = 0; mem_read = 0; mem_write = 0; xfer_byte = 0;
    address = '0; write_data = '0; dm_ack = 0; dm_rdata = '0;
  endtask

  // One operation from accept to the idle cycle after DONE; ack_at = REQ cycle of ack, 0 = never
  task automatic run_op(input logic rd, input logic wr, input logic bt,
                        input logic [63:0] a, input logic [63:0] wd,
                        input int ack_at, input logic [63:0] rdt);
    logic mem, we, mis;
    logic [7:0] bm;
    logic [63:0] bwd, lane;
    int n, c;
    mem = rd | wr;
    we  = wr & ~rd;
    mis = mem & ~bt & (a[2:0] != 3'd0);
    bm  = bt ? (8'd1 << a[2:0]) : 8'hFF;
    bwd = bt ? {8{wd[7:0]}} : wd;
    lane = (rdt >> (8 * a[2:0])) & 64'hFF;
    done_cyc = -1; st_cnt = 0; rq_cnt = 0; last_bm = '0; last_wd = '0;
    c = 0;
    op_valid = 1; mem_read = rd; mem_write = wr; xfer_byte = bt;
    address = a; write_data = wd;
    set_exp(mem, 0, 0, 0, '0, '0, '0);
    step(c); c++;
    idle_inputs();
    if (mem && !mis) begin
      m_al = 0; m_be = 0;
      n = (ack_at > 0) ? ack_at : TMO;
      for (int j = 1; j <= n; j++) begin
        dm_ack = (j == ack_at); dm_rdata = rdt;
        set_exp(1, 1, 0, we, bm, a, bwd);
        step(c); c++;
      end
      dm_ack = 0; dm_rdata = '0;
      if (ack_at > 0) begin
        if (!we) m_rd = bt ? lane : rdt;
        m_ad = a;
      end else begin
        m_be = 1; m_rd = '0;
      end
    end else if (mis) begin
      m_al = 1; m_be = 0; m_rd = '0;
    end else begin
      m_ad = a;
    end
    set_exp(0, 0, 1, 0, '0, '0, '0);
    step(c); c++;
    // A stray acknowledge outside REQ must have no effect
    dm_ack = 1; dm_rdata = 64'hDEAD_BEEF_0BAD_F00D;
    set_exp(0, 0, 0, 0, '0, '0, '0);
    step(c);
    dm_ack = 0; dm_rdata = '0;
  endtask

  task automatic reset_model();
    m_rd = '0; m_ad = '0; m_al = 0; m_be = 0;
    set_exp(0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_dm_req"}, dm_req, 0);
    check({tag, "_dm_we"}, dm_we, 0);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_align_err"}, align_err, 0);
    check({tag, "_bus_err"}, bus_err, 0);
    check({tag, "_dm_addr"}, dm_addr, 0);
    check({tag, "_dm_wdata"}, dm_wdata, 0);
    check({tag, "_dm_bmask"}, dm_bmask, 0);
    check({tag, "_dm_read_data"}, dm_read_data, 0);
    check({tag, "_dm_address"}, dm_address, 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_reset("por");
    @(posedge clk); #1;
    reset = 0;
    chk_en = 1;

    // LDUR 0x10, ack in first REQ cycle
    run_op(1, 0, 0, 64'h10, '0, 1, 64'h1122334455667788);
    check("ldur_done_cyc", done_cyc, 2);
    check("ldur_stall_cnt", st_cnt, 2);
    check("ldur_rdata", dm_read_data, 64'h1122334455667788);
    check("ldur_addr", dm_address, 64'h10);

    // LDURB 0x13, ack after 3 REQ cycles
    run_op(1, 0, 1, 64'h13, '0, 3, 64'hAABBCCDDEEFF0011);
    check("ldurb_rdata", dm_read_data, 64'hEE);
    check("ldurb_done_cyc", done_cyc, 4);
    check("ldurb_stall_cnt", st_cnt, 4);

    // STURB 0x21, byte replicated in all lanes
    run_op(0, 1, 1, 64'h21, 64'h5A, 2, '0);
    check("sturb_bmask", last_bm, 8'h02);
    check("sturb_wdata", last_wd, 64'h5A5A5A5A5A5A5A5A);
    check("sturb_req_cnt", rq_cnt, 2);
    check("sturb_rdata_kept", dm_read_data, 64'hEE);

    // STUR misaligned 0x0C
    run_op(0, 1, 0, 64'h0C, 64'h1234, 0, '0);
    check("align_flag", align_err, 1);
    check("align_req_cnt", rq_cnt, 0);
    check("align_done_cyc", done_cyc, 1);
    check("align_rdata", dm_read_data, 0);

    // Next valid op clears align_err
    run_op(1, 0, 0, 64'h40, '0, 1, 64'h0123456789ABCDEF);
    check("align_cleared", align_err, 0);

    // LDUR timeout
    run_op(1, 0, 0, 64'h08, '0, 0, '0);
    check("tmo_req_cnt", rq_cnt, 16);
    check("tmo_done_cyc", done_cyc, 17);
    check("tmo_bus_err", bus_err, 1);
    check("tmo_rdata", dm_read_data, 0);

    // Non-memory op passes address through, no stall
    run_op(0, 0, 0, 64'h1234, '0, 0, '0);
    check("nop_done_cyc", done_cyc, 1);
    check("nop_stall_cnt", st_cnt, 0);
    check("nop_addr", dm_address, 64'h1234);

    // Aligned STUR, LDURB top lane, read+write treated as read
    run_op(0, 1, 0, 64'h18, 64'hCAFEF00DDEADBEEF, 1, '0);
    check("stur_wdata", last_wd, 64'hCAFEF00DDEADBEEF);
    check("stur_bmask", last_bm, 8'hFF);
    run_op(1, 0, 1, 64'h07, '0, 2, 64'h8877665544332211);
    check("ldurb7_rdata", dm_read_data, 64'h88);
    run_op(1, 1, 0, 64'h30, 64'h5555, 1, 64'h0F0F0F0F0F0F0F0F);
    check("rw_rdata", dm_read_data, 64'h0F0F0F0F0F0F0F0F);

    // Reset asserted during REQ cycle 3
    chk_en = 0;
    op_valid = 1; mem_read = 1; address = 64'h50;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_req", dm_req, 1);
    #2 reset = 1;
    #1 check_all_reset("arst");
    @(posedge clk); #1;
    reset = 0;
    reset_model();
    chk_en = 1;
    run_op(1, 0, 0, 64'h60, '0, 1, 64'h00000000CAFEBABE);
    check("post_rst_done_cyc", done_cyc, 2);
    check("post_rst_rdata", dm_read_data, 64'hCAFEBABE);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage controller for the pipelined CPU: accepts one load/store per operation from the EX/MEM pipeline register, drives a variable-latency data-memory request/acknowledge bus, and returns registered `dm_read_data` and `dm_address` to the write-back stage. It asserts `stall` for the whole memory access so the earlier stages freeze. It handles LDUR/STUR (doubleword) and LDURB/STURB (byte) accesses, doubleword-alignment checking, and bus timeout.

## Interface
- `TIMEOUT`, default 16: maximum REQ-state cycles without `dm_ack` before aborting (≥2).
- `clk  input  1  system clock, all state updates on rising edge`
- `reset  input  1  asynchronous, active-high; forces IDLE and reset values`
- `op_valid  input  1  EX/MEM holds a valid instruction this cycle`
- `mem_read  input  1  load`
- `mem_write  input  1  store`
- `xfer_byte  input  1  1 = byte access, 0 = doubleword`
- `address  input  64  effective address from ALU`
- `write_data  input  64  store data (byte store uses [7:0])`
- `dm_req  output  1  memory request, held until ack or timeout`
- `dm_we  output  1  1 = write request`
- `dm_addr  output  64  request address`
- `dm_wdata  output  64  write data`
- `dm_bmask  output  8  byte-lane enables`
- `dm_ack  input  1  memory completes request this cycle`
- `dm_rdata  input  64  read data, valid when dm_ack`
- `dm_read_data  output  64  registered load result to write-back`
- `dm_address  output  64  registered address/ALU result to write-back`
- `stall  output  1  freeze IF/ID/EX`
- `done  output  1  one-cycle pulse: result registers updated`
- `align_err  output  1  sticky until next accepted op: misaligned doubleword`
- `bus_err  output  1  sticky until next accepted op: timeout`

## Operation
- States: IDLE, REQ, DONE.
- IDLE, `op_valid` with `mem_read` or `mem_write`: latch address, write_data, xfer_byte, direction; clear both error flags; `stall`=1 combinationally this cycle.
  - doubleword and `address[2:0]`≠0: set `align_err`, `dm_read_data`←0, go DONE; no bus access.
  - else go REQ, timeout counter←0.
- `mem_read` and `mem_write` both high: treated as read.
- IDLE, `op_valid` with neither: `dm_address`←`address`, `dm_read_data` unchanged, `done` pulse next cycle via DONE; no stall.
- REQ: `dm_req`=1; `dm_we`, `dm_addr`, `dm_wdata`, `dm_bmask` stable from latched values.
  - Doubleword: `dm_bmask`=8'hFF, `dm_wdata`=latched data.
  - Byte: `dm_bmask`=1<<addr[2:0]; `dm_wdata`=data[7:0] replicated in all eight lanes.
  - `dm_ack`: loads capture `dm_rdata` (byte: lane addr[2:0] zero-extended to 64 bits); stores leave `dm_read_data` unchanged; `dm_address`←latched address; go DONE.
  - counter = TIMEOUT−1 without ack: `dm_req` drops, `bus_err`←1, `dm_read_data`←0, go DONE.
- DONE: `done`=1, `stall`=0, go IDLE; new op may be accepted the following cycle.
- `dm_ack` outside REQ ignored.

## Timing
- Reset values: state IDLE; `dm_req`, `dm_we`, `stall`, `done`, `align_err`, `bus_err` = 0; `dm_addr`, `dm_wdata`, `dm_read_data`, `dm_address` = 0; `dm_bmask`=0.
- Reset mid-REQ: `dm_req` deasserts asynchronously; no `done`.
- Op accepted cycle 0; REQ from cycle 1; ack in cycle k ≥1 → DONE (done=1) in cycle k+1; minimum latency 2 cycles.
- `stall`=1 from cycle 0 through cycle k inclusive; 0 in DONE.
- Timeout: REQ occupies exactly TIMEOUT cycles, DONE at cycle TIMEOUT+1.
- Alignment error: DONE at cycle 1, `dm_req` never asserted.
- Outputs except `stall` (IDLE term) are registered or state-decoded; no combinational path from `dm_ack` to `stall`.

## Test plan
- LDUR addr 0x10, ack in first REQ cycle with rdata 0x1122334455667788 → done at cycle 2, `dm_read_data`=0x1122334455667788, `dm_address`=0x10, stall high cycles 0–1.
- LDURB addr 0x13, rdata 0xAABBCCDDEEFF0011, ack after 3 REQ cycles → `dm_read_data`=0x00000000000000EE, done at cycle 4.
- STURB addr 0x21, write_data 0x5A → `dm_bmask`=8'h02, `dm_wdata`=0x5A5A5A5A5A5A5A5A, `dm_we`=1, held until ack.
- STUR addr 0x0C → `align_err`=1, `dm_req` never high, done at cycle 1; next valid op clears `align_err`.
- LDUR with no ack, TIMEOUT=16 → `dm_req` high 16 cycles, `bus_err`=1, `dm_read_data`=0, done at cycle 17; also reset asserted at REQ cycle 3 → `dm_req` low immediately, all outputs at reset values.
